// File: rtl/rng_address_sched.sv
// rng_address_sched
//
// Round-robin scheduler that shares one rngAddress modulo unit
// (repeated-subtraction which mod betterNeighborCount) among NREQ search
// engines. A job is: grant one requester, latch its operands, pulse the
// unit's start, wait for its sticky done, return the result to the
// requester, then clear the unit for the next job.
//
// Optional feature macro: RNG_SCHED_ZERO_GUARD_EN
//   defined   : a granted request with count 0 bypasses the unit and is
//               answered from RESP with rsp_address = which (2-cycle job).
//   undefined : count 0 is forwarded to the unit, which never finishes; the
//               scheduler then waits in WAIT until nrst. Callers must not
//               issue count 0.
//
// Parameters
//   NREQ         number of requesters (2..8)
//   W            operand / result width, matches the unit
// Ports
//   clock        rising-edge clock
//   nrst         asynchronous active-low reset
//   req          per-requester level request, held until its rsp_done
//   req_which    per-requester dividend, slice i = [i*W +: W]
//   req_count    per-requester divisor, slice i = [i*W +: W]
//   rsp_done     one-hot one-cycle pulse to the served requester
//   rsp_address  result, valid in the rsp_done cycle, held otherwise
//   busy         high in every state except IDLE
//   unit_start   to the unit's start_rng_address
//   unit_which   to the unit's which, stable for the whole job
//   unit_count   to the unit's betterNeighborCount, stable for the whole job
//   unit_clr_n   unit reset request; integrate as unit_clr_n & nrst
//   unit_address from the unit's rng_address
//   unit_done    from the unit's done_rng_address (sticky until cleared)
// All outputs are registered.

module rng_address_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_which,
  input  logic [NREQ*W-1:0] req_count,
  output logic [NREQ-1:0]   rsp_done,
  output logic [W-1:0]      rsp_address,
  output logic              busy,
  output logic              unit_start,
  output logic [W-1:0]      unit_which,
  output logic [W-1:0]      unit_count,
  output logic              unit_clr_n,
  input  logic [W-1:0]      unit_address,
  input  logic              unit_done
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PtrW:0] NreqW = (PtrW + 1)'(NREQ);

`ifdef RNG_SCHED_ZERO_GUARD_EN
  localparam bit ZeroGuard = 1'b1;
`else
  localparam bit ZeroGuard = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StResp,
    StClear
  } state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] gnt_q, gnt_d;
  logic            bypass_q, bypass_d;
  logic [NREQ-1:0] rsp_done_q, rsp_done_d;
  logic [W-1:0]    rsp_address_q, rsp_address_d;
  logic            busy_q, busy_d;
  logic            unit_start_q, unit_start_d;
  logic [W-1:0]    unit_which_q, unit_which_d;
  logic [W-1:0]    unit_count_q, unit_count_d;
  logic            unit_clr_n_q, unit_clr_n_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] rot_idx [NREQ];
  logic            pick_valid;
  logic [PtrW-1:0] pick_idx;
  logic [W-1:0]    pick_which;
  logic [W-1:0]    pick_count;
  logic            zero_skip;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      logic [PtrW:0] sum;
      sum = {1'b0, ptr_q} + (PtrW + 1)'(k);
      if (sum >= NreqW) begin
        sum = sum - NreqW;
      end
      rot_idx[k] = sum[PtrW-1:0];
    end
  end

  // Walk offsets from the far end so the smallest offset with a request wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rot_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx[k];
      end
    end
  end

  assign pick_which = req_which[pick_idx*W +: W];
  assign pick_count = req_count[pick_idx*W +: W];
  assign zero_skip  = ZeroGuard && (pick_count == '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = zero_skip ? StResp : StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (unit_done) begin
          state_d = StResp;
        end
      end
      // A bypassed job never touched the unit, so there is nothing to clear.
      StResp:  state_d = bypass_q ? StIdle : StClear;
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d         = gnt_q;
    bypass_d      = bypass_q;
    ptr_d         = ptr_q;
    rsp_address_d = rsp_address_q;
    unit_which_d  = unit_which_q;
    unit_count_d  = unit_count_q;

    if (state_q == StIdle && pick_valid) begin
      gnt_d    = pick_idx;
      bypass_d = zero_skip;
      if (zero_skip) begin
        rsp_address_d = pick_which;
      end else begin
        // Held until the next grant; the unit re-reads count every step.
        unit_which_d = pick_which;
        unit_count_d = pick_count;
      end
    end

    if (state_q == StWait && unit_done) begin
      rsp_address_d = unit_address;
    end

    if (state_q == StResp) begin
      ptr_d = (gnt_q == PtrW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
    end

    for (int i = 0; i < NREQ; i++) begin
      rsp_done_d[i] = (state_d == StResp) && (gnt_d == PtrW'(i));
    end

    busy_d       = (state_d != StIdle);
    unit_start_d = (state_d == StStart);
    unit_clr_n_d = (state_d != StClear);
  end

  // ---------------------------------------------------------------------------
  // Output and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      ptr_q         <= '0;
      gnt_q         <= '0;
      bypass_q      <= 1'b0;
      rsp_done_q    <= '0;
      rsp_address_q <= '0;
      busy_q        <= 1'b0;
      unit_start_q  <= 1'b0;
      unit_which_q  <= '0;
      unit_count_q  <= '0;
      // Keep the unit cleared while in reset.
      unit_clr_n_q  <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      bypass_q      <= bypass_d;
      rsp_done_q    <= rsp_done_d;
      rsp_address_q <= rsp_address_d;
      busy_q        <= busy_d;
      unit_start_q  <= unit_start_d;
      unit_which_q  <= unit_which_d;
      unit_count_q  <= unit_count_d;
      unit_clr_n_q  <= unit_clr_n_d;
    end
  end

  assign rsp_done    = rsp_done_q;
  assign rsp_address = rsp_address_q;
  assign busy        = busy_q;
  assign unit_start  = unit_start_q;
  assign unit_which  = unit_which_q;
  assign unit_count  = unit_count_q;
  assign unit_clr_n  = unit_clr_n_q;

endmodule

// File: tb/tb_rng_address_sched.sv
module tb_rng_address_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;

  logic              clock = 1'b0;
  logic              nrst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_which;
  logic [NREQ*W-1:0] req_count;
  logic [NREQ-1:0]   rsp_done;
  logic [W-1:0]      rsp_address;
  logic              busy;
  logic              unit_start;
  logic [W-1:0]      unit_which;
  logic [W-1:0]      unit_count;
  logic              unit_clr_n;
  logic [W-1:0]      unit_address;
  logic              unit_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  rng_address_sched #(
    .NREQ(NREQ),
    .W   (W)
  ) dut (
    .clock       (clock),
    .nrst        (nrst),
    .req         (req),
    .req_which   (req_which),
    .req_count   (req_count),
    .rsp_done    (rsp_done),
    .rsp_address (rsp_address),
    .busy        (busy),
    .unit_start  (unit_start),
    .unit_which  (unit_which),
    .unit_count  (unit_count),
    .unit_clr_n  (unit_clr_n),
    .unit_address(unit_address),
    .unit_done   (unit_done)
  );

  // Stand-in for the rngAddress unit: fixed latency, samples its operand
  // ports at completion time, sticky done until cleared, never finishes on 0.
  logic         unit_rst_n;
  logic         u_run;
  logic         u_done;
  int           u_cnt;
  logic [W-1:0] u_addr;

  assign unit_rst_n   = unit_clr_n & nrst;
  assign unit_done    = u_done;
  assign unit_address = u_addr;

  always @(posedge clock or negedge unit_rst_n) begin
    if (!unit_rst_n) begin
      u_run  <= 1'b0;
      u_done <= 1'b0;
      u_cnt  <= 0;
      u_addr <= '0;
    end else if (unit_start) begin
      u_run <= 1'b1;
      u_cnt <= 0;
    end else if (u_run && !u_done && unit_count != '0) begin
      if (u_cnt == 2) begin
        u_done <= 1'b1;
        u_addr <= unit_which % unit_count;
      end
      u_cnt <= u_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] which, input logic [W-1:0] count);
    req_which[i*W +: W] = which;
    req_count[i*W +: W] = count;
  endtask

  // Advance until a response appears (at least one clock); bounded.
  task automatic run_job(output logic [NREQ-1:0] dv, output logic [W-1:0] ad,
                         output int starts);
    int cyc;
    cyc    = 0;
    starts = 0;
    do begin
      tick();
      if (unit_start) starts++;
      cyc++;
    end while (rsp_done == '0 && cyc < 60);
    check("job_timeout", 32'(cyc < 60), 32'd1);
    dv = rsp_done;
    ad = rsp_address;
  endtask

  task automatic reset_pulse();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
  endtask

  logic [NREQ-1:0] dv;
  logic [W-1:0]    ad;
  int              st;

  initial begin
    nrst      = 1'b1;
    req       = '0;
    req_which = '0;
    req_count = '0;
    #1 nrst   = 1'b0;
    #2;
    // Reset values
    check("rst_rsp_done", 32'(rsp_done), 32'h0);
    check("rst_rsp_address", 32'(rsp_address), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_unit_start", 32'(unit_start), 32'h0);
    check("rst_unit_which", 32'(unit_which), 32'h0);
    check("rst_unit_count", 32'(unit_count), 32'h0);
    check("rst_unit_clr_n", 32'(unit_clr_n), 32'h0);
    tick();
    nrst = 1'b1;
    #1 check("clr_n_before_edge", 32'(unit_clr_n), 32'h0);
    tick();
    check("clr_n_after_edge", 32'(unit_clr_n), 32'h1);

    // Single request: 100 mod 7 = 2
    set_op(0, 16'd100, 16'd7);
    req = 4'b0001;
    run_job(dv, ad, st);
    check("single_done", 32'(dv), 32'h1);
    check("single_addr", 32'(ad), 32'd2);
    check("single_starts", 32'(st), 32'd1);
    check("single_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    check("single_clear_clr_n", 32'(unit_clr_n), 32'h0);
    check("single_clear_done", 32'(rsp_done), 32'h0);
    check("single_addr_hold", 32'(rsp_address), 32'd2);
    tick();
    check("single_idle_clr_n", 32'(unit_clr_n), 32'h1);
    check("single_idle_busy", 32'(busy), 32'h0);
    tick();
    check("single_idle_start", 32'(unit_start), 32'h0);

    // Round-robin from a fresh ptr = 0, all requests held
    reset_pulse();
    for (int i = 0; i < NREQ; i++) set_op(i, W'(10 + i), 16'd5);
    req = 4'b1111;
    begin
      logic [NREQ-1:0] exp_dv [5];
      logic [W-1:0]    exp_ad [5];
      exp_dv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_ad = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
      for (int j = 0; j < 5; j++) begin
        run_job(dv, ad, st);
        check($sformatf("rr_done_%0d", j), 32'(dv), 32'(exp_dv[j]));
        check($sformatf("rr_addr_%0d", j), 32'(ad), 32'(exp_ad[j]));
        check($sformatf("rr_starts_%0d", j), 32'(st), 32'd1);
      end
    end
    req = '0;
    tick();
    tick();

    // Operand stability; requester also drops req mid-job. 50 mod 7 = 1
    set_op(1, 16'd50, 16'd7);
    req = 4'b0010;
    tick();
    check("stab_start", 32'(unit_start), 32'h1);
    check("stab_which0", 32'(unit_which), 32'd50);
    check("stab_count0", 32'(unit_count), 32'd7);
    tick();
    check("stab_start_pulse", 32'(unit_start), 32'h0);
    set_op(1, 16'd99, 16'd4);
    req = '0;
    tick();
    check("stab_which1", 32'(unit_which), 32'd50);
    check("stab_count1", 32'(unit_count), 32'd7);
    run_job(dv, ad, st);
    check("stab_done", 32'(dv), 32'h2);
    check("stab_addr", 32'(ad), 32'd1);
    tick();
    tick();

    // which < count, and count = 1
    set_op(0, 16'd3, 16'd9);
    req = 4'b0001;
    run_job(dv, ad, st);
    check("small_done", 32'(dv), 32'h1);
    check("small_addr", 32'(ad), 32'd3);
    req = '0;
    tick();
    tick();
    set_op(1, 16'hFFFF, 16'd1);
    req = 4'b0010;
    run_job(dv, ad, st);
    check("max_done", 32'(dv), 32'h2);
    check("max_addr", 32'(ad), 32'd0);
    req = '0;
    tick();
    tick();

    // Reset mid-WAIT (ptr is 2 here, job granted to 3)
    set_op(3, 16'd20, 16'd6);
    req = 4'b1000;
    tick();
    tick();
    tick();
    check("mid_busy_pre", 32'(busy), 32'h1);
    nrst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(rsp_done), 32'h0);
    check("mid_rst_addr", 32'(rsp_address), 32'h0);
    check("mid_rst_which", 32'(unit_which), 32'h0);
    check("mid_rst_count", 32'(unit_count), 32'h0);
    check("mid_rst_clr_n", 32'(unit_clr_n), 32'h0);
    check("mid_rst_start", 32'(unit_start), 32'h0);
    req = '0;
    tick();
    nrst = 1'b1;
    tick();
    // ptr restarts at 0: requester 1 ahead of 2. 19 mod 5 = 4, 30 mod 7 = 2
    set_op(1, 16'd19, 16'd5);
    set_op(2, 16'd30, 16'd7);
    req = 4'b0110;
    run_job(dv, ad, st);
    check("post_rst_done1", 32'(dv), 32'h2);
    check("post_rst_addr1", 32'(ad), 32'd4);
    req = 4'b0100;
    run_job(dv, ad, st);
    check("post_rst_done2", 32'(dv), 32'h4);
    check("post_rst_addr2", 32'(ad), 32'd2);
    req = '0;
    tick();
    tick();
    check("post_rst_idle", 32'(busy), 32'h0);

`ifdef RNG_SCHED_ZERO_GUARD_EN
    // Zero count bypasses the unit
    set_op(3, 16'h1234, 16'd0);
    req = 4'b1000;
    begin
      int starts;
      starts = 0;
      tick();
      if (unit_start) starts++;
      check("zg_done", 32'(rsp_done), 32'h8);
      check("zg_addr", 32'(rsp_address), 32'h1234);
      req = '0;
      tick();
      if (unit_start) starts++;
      check("zg_idle_busy", 32'(busy), 32'h0);
      check("zg_clr_n", 32'(unit_clr_n), 32'h1);
      tick();
      if (unit_start) starts++;
      check("zg_no_start", 32'(starts), 32'd0);
    end
`else
    // Zero count is forwarded and the job never completes
    set_op(0, 16'd5, 16'd0);
    req = 4'b0001;
    begin
      int dones;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (rsp_done != '0) dones++;
      end
      check("zero_hang_dones", 32'(dones), 32'd0);
      check("zero_hang_busy", 32'(busy), 32'h1);
      check("zero_hang_count", 32'(unit_count), 32'd0);
    end
    req = '0;
    nrst = 1'b0;
    #1 check("zero_hang_rst", 32'(busy), 32'h0);
    tick();
    nrst = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
